// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the single register file write port among NREQ writeback sources.
// Grant, write enable, address and data are all registered; one grant per request.
module regfile_wr_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 4
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Hold,
  input  logic [NREQ-1:0]    Req,
  input  logic [NREQ*AW-1:0] ReqAddr,
  input  logic [NREQ*DW-1:0] ReqData,
  output logic [NREQ-1:0]    Gnt,
  output logic               WrEn,
  output logic [AW-1:0]      WrAddr,
  output logic [DW-1:0]      WrData
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic [PW-1:0]   ptr_q, ptr_d;

  logic [AW-1:0]   req_addr [NREQ];
  logic [DW-1:0]   req_data [NREQ];
  logic [NREQ-1:0] elig;
  logic            found;
  logic [PW-1:0]   win;
  logic [PW:0]     sum;
  logic [PW-1:0]   idx;

  for (genvar i = 0; i < NREQ; i++) begin : gen_split
    assign req_addr[i] = ReqAddr[i*AW +: AW];
    assign req_data[i] = ReqData[i*DW +: DW];
  end

  // A requester whose grant is currently high is not eligible again this cycle.
  assign elig = Req & ~gnt_q;

  // Scan ptr, ptr+1, ... with explicit wrap so non-power-of-2 NREQ works.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      idx = sum[PW-1:0];
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    gnt_d     = '0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ptr_d     = ptr_q;
    if (!Hold && found) begin
      gnt_d[win] = 1'b1;
      wr_en_d    = 1'b1;
      wr_addr_d  = req_addr[win];
      wr_data_d  = req_data[win];
      ptr_d      = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      gnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ptr_q     <= '0;
    end else begin
      gnt_q     <= gnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ptr_q     <= ptr_d;
    end
  end

  assign Gnt    = gnt_q;
  assign WrEn   = wr_en_q;
  assign WrAddr = wr_addr_q;
  assign WrData = wr_data_q;

endmodule
